// File: rtl/boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM state encoding
// and the error codes reported on the error port.
package boot_loader_pkg;

    localparam logic [2:0] ST_HDR   = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHKS  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a framed stream (length header, program words, checksum),
// writes the program into IMEM and holds the core in reset until it verifies.
module imem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  reload,
    output logic                  core_rst,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done,
    output logic [1:0]            error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // One extra bit so a full-depth frame length (DEPTH) fits.
    localparam int CW    = ADDR_WIDTH + 1;

    logic [2:0]            state;
    logic [CW-1:0]         len;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] sum;

    logic                  accept;
    logic [CW-1:0]         hdr_n;
    logic                  hdr_ok;
    logic [CW-1:0]         count_nxt;

    assign in_ready  = (state == ST_HDR) || (state == ST_LOAD) || (state == ST_CHKS);
    assign accept    = in_valid && in_ready;
    assign hdr_n     = in_data[CW-1:0];
    assign hdr_ok    = (in_data[DATA_WIDTH-1:CW] == '0) && (hdr_n != '0) &&
                       (hdr_n <= CW'(DEPTH));
    assign count_nxt = count + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HDR;
            core_rst <= 1'b1;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            error    <= ERR_NONE;
            len      <= '0;
            count    <= '0;
            sum      <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            len   <= hdr_n;
                            count <= '0;
                            sum   <= '0;
                            state <= ST_LOAD;
                        end else begin
                            error <= ERR_LEN;
                            state <= ST_ERROR;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= count[ADDR_WIDTH-1:0];
                        wr_data <= in_data;
                        sum     <= sum + in_data;
                        count   <= count_nxt;
                        if (count_nxt == len) state <= ST_CHKS;
                    end
                end
                ST_CHKS: begin
                    if (accept) begin
                        if (in_data == sum) begin
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                            state    <= ST_RUN;
                        end else begin
                            error <= ERR_CSUM;
                            state <= ST_ERROR;
                        end
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        core_rst <= 1'b1;
                        done     <= 1'b0;
                        state    <= ST_HDR;
                    end
                end
                ST_ERROR: begin
                    if (reload) begin
                        error <= ERR_NONE;
                        state <= ST_HDR;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: header table, scoreboarded IMEM
// writes, and hand-written sequences for checksum, reset and reload corners.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        reload;
    logic        core_rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        done;
    logic [1:0]  error;

    imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .reload(reload), .core_rst(core_rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hdr;
        logic [1:0]  err;
        logic        rdy;
    } hvec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int          pass_cnt = 0;
    int          total    = 0;
    int          cyc      = 0;
    wr_t         exp_q[$];
    logic [31:0] prog[256];
    hvec_t       hv[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Every write must be expected, in order, and land in the cycle of acceptance.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", wr_data, e.data);
                chk("wr_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic do_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_en",    32'(wr_en),    32'd0);
        chk("rst_wr_addr",  32'(wr_addr),  32'd0);
        chk("rst_wr_data",  wr_data,       32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_error",    32'(error),    32'd0);
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_prog(input logic [31:0] w, input int idx, input int gap);
        wr_t e;
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk); #1;
        e.addr = 8'(idx); e.data = w; e.cyc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        in_data  = 32'h0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Sends header, prog[0..n-1] and (bench-computed sum + adj) as checksum.
    task automatic frame(input int n, input int gap, input logic [31:0] adj);
        logic [31:0] s = 32'h0;
        send(32'(n), gap);
        for (int i = 0; i < n; i++) begin
            send_prog(prog[i], i, gap);
            s = s + prog[i];
        end
        send(s + adj, 0);
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_done"},     32'(done),     32'd1);
        chk({tag, "_error"},    32'(error),    32'd0);
        chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_q_empty"},  32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    initial begin
        hv[0] = '{32'h0000_0000, 2'b01, 1'b0};
        hv[1] = '{32'h0000_0101, 2'b01, 1'b0};
        hv[2] = '{32'h0000_0200, 2'b01, 1'b0};
        hv[3] = '{32'h8000_0001, 2'b01, 1'b0};
        hv[4] = '{32'h0000_0001, 2'b00, 1'b1};
        hv[5] = '{32'h0000_0100, 2'b00, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; reload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_rst();

        // Header validation table: no writes may follow any of these.
        for (int i = 0; i < 6; i++) begin
            do_rst();
            send(hv[i].hdr, 1);
            chk($sformatf("hdr%0d_error", i),    32'(error),    32'(hv[i].err));
            chk($sformatf("hdr%0d_in_ready", i), 32'(in_ready), 32'(hv[i].rdy));
            chk($sformatf("hdr%0d_core_rst", i), 32'(core_rst), 32'd1);
        end

        // Normal load with the literal checksum.
        do_rst();
        send(32'd3, 0);
        send_prog(32'h0050_0093, 0, 0);
        send_prog(32'h0030_0113, 1, 0);
        send_prog(32'h0020_81B3, 2, 0);
        send(32'h00A0_8359, 0);
        chk_run("normal");

        // Bad checksum, then reload out of ERROR.
        do_rst();
        send(32'd3, 0);
        send_prog(32'h0050_0093, 0, 0);
        send_prog(32'h0030_0113, 1, 0);
        send_prog(32'h0020_81B3, 2, 0);
        send(32'h00A0_835A, 0);
        chk("badcs_error",    32'(error),    32'd2);
        chk("badcs_done",     32'(done),     32'd0);
        chk("badcs_core_rst", 32'(core_rst), 32'd1);
        chk("badcs_in_ready", 32'(in_ready), 32'd0);
        send(32'h1234_5678, 2);
        chk("badcs_hold",     32'(error),    32'd2);
        pulse_reload();
        chk("err_reload_error",    32'(error),    32'd0);
        chk("err_reload_in_ready", 32'(in_ready), 32'd1);
        chk("err_reload_core_rst", 32'(core_rst), 32'd1);

        // Valid gaps of 2 cycles between every word.
        prog[0] = 32'h0050_0093; prog[1] = 32'h0030_0113; prog[2] = 32'h0020_81B3;
        do_rst();
        frame(3, 2, 32'h0);
        chk_run("gaps");

        // Full-depth frame.
        for (int i = 0; i < 256; i++) prog[i] = $urandom;
        do_rst();
        frame(256, 0, 32'h0);
        chk_run("full");
        chk("full_last_addr", 32'(wr_addr), 32'h0000_00FF);

        // Reset after 2 of 3 words, then a fresh 1-word frame.
        do_rst();
        send(32'd3, 0);
        send_prog(32'hAAAA_0001, 0, 0);
        send_prog(32'hAAAA_0002, 1, 0);
        do_rst();
        send(32'd1, 0);
        send_prog(32'h0000_0013, 0, 0);
        send(32'h0000_0013, 0);
        chk_run("midrst");

        // In RUN the stream is ignored; reload ignored mid-load too.
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_run("run_ignore");
        pulse_reload();
        chk("reload_core_rst", 32'(core_rst), 32'd1);
        chk("reload_done",     32'(done),     32'd0);
        chk("reload_in_ready", 32'(in_ready), 32'd1);
        prog[0] = 32'h1111_1111; prog[1] = 32'h2222_2222;
        send(32'd2, 0);
        send_prog(prog[0], 0, 0);
        pulse_reload();
        send_prog(prog[1], 1, 0);
        send(32'h3333_3333, 0);
        chk_run("reload_frame");

        repeat (2) @(posedge clk);
        #1;
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
